// File: rtl/nes_pad_pkg.sv
// Shared definitions for the NES pad poll scheduler: FSM states,
// button bit positions and default timing values.
package nes_pad_pkg;

  // Poll sequencer states, in the order a poll walks through them.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_CLK_LO = 3'd2,
    ST_CLK_HI = 3'd3,
    ST_DONE   = 3'd4
  } pad_state_t;

  // Bit position of each button inside a committed snapshot.
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int NUM_BTNS = 8;

  // Defaults for a 27 MHz system clock: 6 us half bit, 60 Hz polling.
  localparam int DEF_HALF_CYC    = 162;
  localparam int DEF_POLL_PERIOD = 450000;
  localparam int DEF_AUTO_POLL   = 1;

endpackage

// File: rtl/nes_cpu_pad_shifter.sv
// CPU-visible $4016/$4017 shift register for one pad port.
// While strobe is high the register tracks the committed snapshot and a
// read returns button A. With strobe low each read shifts right and fills
// with 1, so reads past the eighth return 1 like the real 4021.
module nes_cpu_pad_shifter
  import nes_pad_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_strobe,
  input  logic                i_rd,
  input  logic [NUM_BTNS-1:0] i_snapshot,
  output logic                o_d
);

  logic [NUM_BTNS-1:0] shreg;

  // Reload while strobed, shift on reads otherwise; register the read bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shreg <= '0;
      o_d   <= 1'b0;
    end else begin
      if (i_strobe) begin
        shreg <= i_snapshot;
      end else if (i_rd) begin
        shreg <= {1'b1, shreg[NUM_BTNS-1:1]};
      end
      if (i_rd) begin
        o_d <= i_strobe ? i_snapshot[0] : shreg[0];
      end
    end
  end

endmodule

// File: rtl/nes_pad_poll_scheduler.sv
// Serial poll sequencer for two NES pads sharing latch and clock lines.
// A poll latches both pads, clocks out seven more bits, and commits one
// 8-bit snapshot per pad (1 = pressed) with a single-cycle o_valid.
// Handshake: o_valid is a one-cycle pulse with no ready; o_pad0/o_pad1
// change only in that cycle and hold otherwise. i_poll_req is a one-cycle
// pulse; a request while busy is remembered once and run afterwards.
// Also hosts the CPU-side $4016/$4017 read emulation for both ports.
module nes_pad_poll_scheduler
  import nes_pad_pkg::*;
#(
  parameter int HALF_CYC    = DEF_HALF_CYC,
  parameter int POLL_PERIOD = DEF_POLL_PERIOD,
  parameter int AUTO_POLL   = DEF_AUTO_POLL
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_poll_req,
  output logic       o_pad_latch,
  output logic       o_pad_clk,
  input  logic [1:0] i_pad_data,
  output logic [7:0] o_pad0,
  output logic [7:0] o_pad1,
  output logic       o_valid,
  output logic       o_busy,
  input  logic       i_cpu_strobe,
  input  logic [1:0] i_cpu_rd,
  output logic [1:0] o_cpu_d
);

  // Counter sized to hold the longest phase (the 2*HALF_CYC latch pulse).
  localparam int CNT_W = $clog2(2 * HALF_CYC);
  localparam int PER_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * HALF_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYC - 1);
  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(POLL_PERIOD - 1);

  pad_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic             pend;
  // Bits 0..6 of the poll in progress; each sample enters at the top and
  // moves down, so bit 0 sits at position 0 once bit 6 has been taken.
  logic [6:0]       cap0;
  logic [6:0]       cap1;

  logic [1:0]       data_meta;
  logic [1:0]       data_sync;

  logic [PER_W-1:0] per_cnt;
  logic             timer_hit;
  logic             trigger;

  // Two-flop synchronizer for the asynchronous pad data lines.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_meta <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      data_meta <= i_pad_data;
      data_sync <= data_meta;
    end
  end

  // Free-running period counter that wraps at POLL_PERIOD-1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      per_cnt <= '0;
    end else if (per_cnt == PER_LAST) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  // A request and a timer hit in the same cycle merge into one trigger.
  assign timer_hit = (AUTO_POLL != 0) && (per_cnt == PER_LAST);
  assign trigger   = i_poll_req || timer_hit;

  // Poll sequencer with registered pad-side outputs and commit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      pend        <= 1'b0;
      cap0        <= '0;
      cap1        <= '0;
      o_pad_latch <= 1'b0;
      o_pad_clk   <= 1'b1;
      o_pad0      <= '0;
      o_pad1      <= '0;
      o_valid     <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_valid <= 1'b0;

      // Only one poll can be queued behind the running one.
      if (trigger && (state != ST_IDLE)) begin
        pend <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (trigger || pend) begin
            state       <= ST_LATCH;
            pend        <= 1'b0;
            cnt         <= '0;
            o_pad_latch <= 1'b1;
            o_busy      <= 1'b1;
          end
        end

        ST_LATCH: begin
          if (cnt == LATCH_LAST) begin
            cap0        <= {~data_sync[0], cap0[6:1]};
            cap1        <= {~data_sync[1], cap1[6:1]};
            bit_idx     <= 3'd1;
            cnt         <= '0;
            o_pad_latch <= 1'b0;
            o_pad_clk   <= 1'b0;
            state       <= ST_CLK_LO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_CLK_LO: begin
          if (cnt == HALF_LAST) begin
            cnt       <= '0;
            o_pad_clk <= 1'b1;
            state     <= ST_CLK_HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_CLK_HI: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              // Last bit goes straight into the committed snapshot.
              o_pad0  <= {~data_sync[0], cap0};
              o_pad1  <= {~data_sync[1], cap1};
              o_valid <= 1'b1;
              state   <= ST_DONE;
            end else begin
              cap0      <= {~data_sync[0], cap0[6:1]};
              cap1      <= {~data_sync[1], cap1[6:1]};
              bit_idx   <= bit_idx + 3'd1;
              o_pad_clk <= 1'b0;
              state     <= ST_CLK_LO;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DONE: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          state       <= ST_IDLE;
          o_pad_latch <= 1'b0;
          o_pad_clk   <= 1'b1;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

  nes_cpu_pad_shifter u_cpu_port0 (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_strobe   (i_cpu_strobe),
    .i_rd       (i_cpu_rd[0]),
    .i_snapshot (o_pad0),
    .o_d        (o_cpu_d[0])
  );

  nes_cpu_pad_shifter u_cpu_port1 (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_strobe   (i_cpu_strobe),
    .i_rd       (i_cpu_rd[1]),
    .i_snapshot (o_pad1),
    .o_d        (o_cpu_d[1])
  );

endmodule

// File: tb/tb_nes_pad_poll_scheduler.sv
// Bench for nes_pad_poll_scheduler: a directed-stimulus instance (HALF_CYC=8,
// manual polling) with a 4021-style pad model, plus a free-running
// auto-poll instance (HALF_CYC=4, POLL_PERIOD=300).
`timescale 1ns/1ps
module tb_nes_pad_poll_scheduler;

  localparam int H      = 8;
  localparam int VALID_LAT = 16 * H + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst = 1'b1;
  logic       rst_b = 1'b1;
  logic       poll_req = 1'b0;
  logic       strobe = 1'b0;
  logic [1:0] cpu_rd = 2'b00;
  logic [1:0] pad_data;

  logic       pad_latch, pad_clk, valid, busy;
  logic [7:0] pad0, pad1;
  logic [1:0] cpu_d;

  // auto-poll instance signals
  logic       req_b = 1'b0;
  logic       strobe_b = 1'b0;
  logic [1:0] rd_b = 2'b00;
  logic [1:0] data_b = 2'b11;
  logic       latch_b, pclk_b, valid_b, busy_b;
  logic [7:0] pad0_b, pad1_b;
  logic [1:0] cpu_d_b;

  nes_pad_poll_scheduler #(.HALF_CYC(H), .POLL_PERIOD(1000), .AUTO_POLL(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_poll_req(poll_req),
    .o_pad_latch(pad_latch), .o_pad_clk(pad_clk), .i_pad_data(pad_data),
    .o_pad0(pad0), .o_pad1(pad1), .o_valid(valid), .o_busy(busy),
    .i_cpu_strobe(strobe), .i_cpu_rd(cpu_rd), .o_cpu_d(cpu_d)
  );

  nes_pad_poll_scheduler #(.HALF_CYC(4), .POLL_PERIOD(300), .AUTO_POLL(1)) dut_auto (
    .i_clk(clk), .i_rst(rst_b), .i_poll_req(req_b),
    .o_pad_latch(latch_b), .o_pad_clk(pclk_b), .i_pad_data(data_b),
    .o_pad0(pad0_b), .o_pad1(pad1_b), .o_valid(valid_b), .o_busy(busy_b),
    .i_cpu_strobe(strobe_b), .i_cpu_rd(rd_b), .o_cpu_d(cpu_d_b)
  );

  // ---------------- pad model (4021-like, active-low out) ----------------
  logic [7:0] btn0 = 8'h00, btn1 = 8'h00;
  logic [7:0] sh0 = 8'h00, sh1 = 8'h00;
  logic       prev_pclk = 1'b1;
  always @(posedge clk) begin
    prev_pclk <= pad_clk;
    if (pad_latch) begin
      sh0 <= btn0;
      sh1 <= btn1;
    end else if (pad_clk && !prev_pclk) begin
      sh0 <= {1'b0, sh0[7:1]};
      sh1 <= {1'b0, sh1[7:1]};
    end
  end
  assign pad_data = {~sh1[0], ~sh0[0]};

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];
  int          exp_t_q[$];
  logic        cpu0_q[$];
  logic        cpu1_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Snapshot monitor: every o_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        check("pad_snapshot", {pad1, pad0}, exp_q.pop_front());
        check("valid_cycle", cyc, exp_t_q.pop_front());
      end
    end
  end

  // CPU read monitor: o_cpu_d is checked the cycle after each read pulse.
  logic [1:0] rd_d = 2'b00;
  always @(posedge clk) rd_d <= cpu_rd;
  always @(negedge clk) begin
    if (!rst && rd_d[0]) begin
      if (cpu0_q.size() == 0) check("unexpected_rd0", 32'd1, 32'd0);
      else check("cpu_d0", cpu_d[0], cpu0_q.pop_front());
    end
    if (!rst && rd_d[1]) begin
      if (cpu1_q.size() == 0) check("unexpected_rd1", 32'd1, 32'd0);
      else check("cpu_d1", cpu_d[1], cpu1_q.pop_front());
    end
  end

  // Auto-poll monitor: consecutive o_valid pulses are 300 cycles apart.
  int auto_cnt = 0;
  int auto_last = 0;
  always @(negedge clk) begin
    if (!rst_b && valid_b) begin
      if (auto_cnt > 0) check("auto_period", cyc - auto_last, 300);
      auto_last = cyc;
      auto_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  // Pulses i_poll_req for one cycle; t is the cycle in which it is high.
  task automatic pulse_req(output int t);
    @(posedge clk); #1;
    poll_req = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    poll_req = 1'b0;
  endtask

  task automatic expect_poll(input logic [7:0] e0, input logic [7:0] e1, input int at);
    exp_q.push_back({e1, e0});
    exp_t_q.push_back(at);
  endtask

  task automatic cpu_read(input logic [1:0] which, input logic e0, input logic e1);
    @(posedge clk); #1;
    if (which[0]) cpu0_q.push_back(e0);
    if (which[1]) cpu1_q.push_back(e1);
    cpu_rd = which;
    @(posedge clk); #1;
    cpu_rd = 2'b00;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete in time");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int t;
  int lat_cnt, first_lat, last_lat, lo_cnt, falls, busy_cnt;
  logic prev_c;
  int e0_seq[10] = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 1};
  int e1_seq[10] = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 1};

  initial begin
    // reset state, checked while reset is held
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_latch", pad_latch, 0);
    check("rst_clk", pad_clk, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_pads", {pad1, pad0}, 16'h0000);
    check("rst_cpu_d", cpu_d, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);

    // timing + data: port0 A+Start, port1 Right+B
    btn0 = 8'h09;
    btn1 = 8'h82;
    @(posedge clk); #1;
    expect_poll(8'h09, 8'h82, cyc + 1 + VALID_LAT);
    pulse_req(t);
    lat_cnt = 0; first_lat = -1; last_lat = -1; lo_cnt = 0; falls = 0; busy_cnt = 0;
    prev_c = 1'b1;
    repeat (VALID_LAT) begin
      @(negedge clk);
      if (pad_latch) begin
        lat_cnt++;
        if (first_lat < 0) first_lat = cyc;
        last_lat = cyc;
      end
      if (!pad_clk) lo_cnt++;
      if (prev_c && !pad_clk) falls++;
      if (busy) busy_cnt++;
      prev_c = pad_clk;
    end
    check("latch_first", first_lat, t + 1);
    check("latch_last", last_lat, t + 2 * H);
    check("latch_cycles", lat_cnt, 2 * H);
    check("clk_falls", falls, 7);
    check("clk_low_cycles", lo_cnt, 7 * H);
    check("busy_cycles", busy_cnt, VALID_LAT);
    @(negedge clk);
    check("busy_after", busy, 0);
    check("clk_idle_after", pad_clk, 1);

    // CPU reads: strobe high then low, ten reads on both ports at once
    @(posedge clk); #1;
    strobe = 1'b1;
    repeat (2) @(posedge clk);
    #1 strobe = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cpu_read(2'b11, e0_seq[i][0], e1_seq[i][0]);
    end
    // strobe held high: every read returns button A, no shifting
    @(posedge clk); #1;
    strobe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_read(2'b11, 1'b1, 1'b0);
    end
    @(posedge clk); #1;
    strobe = 1'b0;

    // pending: two extra requests while busy queue exactly one more poll
    btn0 = 8'h30;
    btn1 = 8'h41;
    @(posedge clk); #1;
    expect_poll(8'h30, 8'h41, cyc + 1 + VALID_LAT);
    expect_poll(8'h30, 8'h41, cyc + 1 + 2 * VALID_LAT + 1);
    pulse_req(t);
    wait_until(t + 20);
    poll_req = 1'b1;
    @(posedge clk); #1;
    poll_req = 1'b0;
    wait_until(t + 40);
    poll_req = 1'b1;
    @(posedge clk); #1;
    poll_req = 1'b0;
    wait_until(t + 2 * VALID_LAT + 20);
    check("pending_drained", exp_q.size(), 0);
    @(negedge clk);
    check("pending_busy_after", busy, 0);

    // reset during CLK_LO of bit 4 aborts the poll without a commit
    btn0 = 8'hFF;
    btn1 = 8'h5A;
    pulse_req(t);
    wait_until(t + 68);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_latch", pad_latch, 0);
    check("abort_clk", pad_clk, 1);
    check("abort_busy", busy, 0);
    check("abort_pads", {pad1, pad0}, 16'h0000);
    check("abort_cpu_d", cpu_d, 2'b00);
    repeat (150) @(negedge clk);
    check("abort_no_valid", exp_q.size(), 0);

    // a fresh request afterwards runs a full normal poll
    @(posedge clk); #1;
    expect_poll(8'hFF, 8'h5A, cyc + 1 + VALID_LAT);
    pulse_req(t);
    wait_until(t + VALID_LAT + 10);
    check("post_reset_drained", exp_q.size(), 0);

    // let the auto-poll instance accumulate several periods
    wait_until(1900);
    check("auto_pulses_seen", (auto_cnt >= 5) ? 1 : 0, 1);
    check("cpu_q_drained", cpu0_q.size() + cpu1_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nes_pad_poll_scheduler.md
Name: nes_pad_poll_scheduler

Overview:
Sequences serial polling of two NES pads that share one latch line and one clock line, each with its own data line. A poll starts either from a periodic internal timer or from an external request. Each poll commits one 8-bit button snapshot per pad. The block also emulates the CPU-visible $4016/$4017 shift-register read behaviour, using the committed snapshots, for the NES core.

Parameters:
HALF_CYC, 162, i_clk cycles per half bit period (6 us at 27 MHz); minimum 4.
POLL_PERIOD, 450000, i_clk cycles between automatic polls (60 Hz at 27 MHz).
AUTO_POLL, 1, 1 = internal period timer issues poll triggers; 0 = only i_poll_req triggers.

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
i_poll_req  in  1  single-cycle poll request (e.g. vblank)
o_pad_latch  out  1  shared latch to both pads, active high
o_pad_clk  out  1  shared pad clock; idles high, pulses low
i_pad_data  in  2  serial data, [0]=port0, [1]=port1; active-low, asynchronous
o_pad0  out  8  committed port0 buttons, 1=pressed
o_pad1  out  8  committed port1 buttons, 1=pressed
o_valid  out  1  one-cycle pulse when o_pad0/o_pad1 update
o_busy  out  1  high while a poll sequence is in progress
i_cpu_strobe  in  1  level of the CPU-written $4016 bit0
i_cpu_rd  in  2  one-cycle read pulses: [0]=$4016, [1]=$4017
o_cpu_d  out  2  registered read bit per port

Behaviour:
- Reset state: FSM IDLE; o_pad_latch=0; o_pad_clk=1; o_pad0=o_pad1=0; o_valid=0; o_busy=0; o_cpu_d=0. Pending flag, period counter and CPU shift regs are all cleared.
- Reset asserted mid-poll aborts the sequence immediately. No commit occurs, and no o_valid pulse is issued.
- i_pad_data passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- Bit order: 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right. Sampled bits are inverted, so pressed reads as 1.
- Trigger: an i_poll_req pulse, or the period counter reaching POLL_PERIOD-1 when AUTO_POLL=1. The period counter wraps to 0 and free-runs.
- FSM states IDLE -> LATCH -> CLK_LO -> CLK_HI -> DONE -> IDLE.
  - IDLE: on trigger (or pending=1), go to LATCH next cycle and clear pending.
  - LATCH: o_pad_latch=1 for 2*HALF_CYC cycles. On the last cycle, sample bit0 for both ports. Set bit index=1.
  - CLK_LO: o_pad_clk=0 for HALF_CYC cycles.
  - CLK_HI: o_pad_clk=1 for HALF_CYC cycles. On the last cycle, sample bit[index]. If index=7, go to DONE; else index+1 and return to CLK_LO.
  - DONE: one cycle. Commit o_pad0/o_pad1 and pulse o_valid.
- Timing: a trigger seen in cycle t gives o_pad_latch high for cycles t+1..t+2H. The 7 low clock pulses follow, and o_valid fires at t+16H+1, where H=HALF_CYC.
- o_busy=1 in LATCH, CLK_LO, CLK_HI and DONE.
- A trigger while busy sets pending (maximum one; further triggers are dropped). The pending poll starts in the first IDLE cycle after DONE.
- A simultaneous i_poll_req and timer trigger count as a single trigger.
- CPU emulation, per port p:
  - While i_cpu_strobe=1, shreg_p reloads from the committed snapshot every cycle.
  - On i_cpu_rd[p], o_cpu_d[p] <= shreg_p[0] on the next cycle.
  - If strobe=0, shreg_p also shifts right, filling with 1. After 8 reads, every further read returns 1.
  - If strobe=1, the read returns the current snapshot bit0 (A) and no shift occurs.
  - o_cpu_d holds its value between reads.
- A commit during a CPU read sequence does not disturb shreg while strobe=0. The new snapshot is seen only at the next strobe=1.
- Both i_cpu_rd bits may pulse in the same cycle; the ports are independent.

Decomposition:
- Shared package nes_pad_pkg: FSM state enum, button bit-index constants (BTN_A..BTN_RIGHT), default timing constants.
- One sub-module, nes_cpu_pad_shifter: one instance per port; holds the strobe/reload/shift-with-1 logic and the o_cpu_d register.

Test Plan:
- Timing, HALF_CYC=8, AUTO_POLL=0: pulse i_poll_req at t -> latch high t+1..t+16, 7 clk low pulses of 8 cycles, o_valid at t+129, o_busy low afterwards.
- Data: pad model port0 presses A+Start (0x09), port1 presses Right+B (0x82), active-low serial -> o_pad0=0x09, o_pad1=0x82 at the o_valid pulse.
- CPU reads: snapshot port0=0x09; strobe 1 then 0; 10 reads on i_cpu_rd[0] -> o_cpu_d[0] sequence 1,0,0,1,0,0,0,0,1,1. Three reads with strobe held at 1 -> 1,1,1.
- Pending: two i_poll_req pulses during busy -> exactly one extra poll starts the cycle after DONE; total two o_valid pulses.
- Reset mid-poll: assert i_rst during CLK_LO of bit 4 -> next cycle latch=0, clk=1, busy=0, outputs 0, no o_valid. A new request then runs a full normal poll.
- Auto poll: AUTO_POLL=1, POLL_PERIOD=300, HALF_CYC=4 -> o_valid pulses exactly every 300 cycles in steady state.
